// File: rtl/data_mem_port_if.sv
// Load/store request and response channels between the
// memory stage and the data memory port.
interface data_mem_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size,
        output req_unsigned, req_addr, req_wdata,
        output resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size,
        input  req_unsigned, req_addr, req_wdata,
        input  resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_port.sv
// Word-organised data RAM with byte lanes, wait states,
// load extension and alignment/range error reporting.
module data_mem_port #(
    parameter int    WORDS_LOG2 = 10,
    parameter int    LATENCY    = 1,
    parameter string INIT_FILE  = ""
) (
    input logic           clk,
    input logic           rst_n,
    data_mem_port_if.slave bus
);
    localparam int AW = WORDS_LOG2;
    localparam logic [3:0] CNT_INIT =
        (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] rdata_q, rdata_n;
    logic        err_q, err_n;

    logic [31:0] mem [0:(1<<AW)-1];

    logic [AW-1:0] widx;
    logic [1:0]    off;
    logic          accept;
    logic          bad_size;
    logic          misal;
    logic          oor;
    logic          err_now;
    logic          we;

    assign widx   = bus.req_addr[AW+1:2];
    assign off    = bus.req_addr[1:0];
    assign accept = (state == IDLE) && bus.req_valid;

    assign bad_size = (bus.req_size == 2'd3);
    assign misal = ((bus.req_size == 2'd1) && off[0])
                 || ((bus.req_size == 2'd2) && (off != 2'd0));
    assign oor     = |bus.req_addr[31:AW+2];
    assign err_now = bad_size || misal || oor;
    assign we      = accept && bus.req_write && !err_now;

    logic [3:0]  be;
    logic [31:0] wd;

    always_comb begin
        be = 4'b0000;
        wd = 32'd0;
        case (bus.req_size)
            2'd0: begin
                be[off] = 1'b1;
                wd      = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                be = off[1] ? 4'b1100 : 4'b0011;
                wd = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = bus.req_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    // Read happens before this edge's store lands: pre-write value.
    logic [31:0] rword, sh, ext;

    always_comb begin
        rword = mem[widx];
        sh    = rword >> {off, 3'b000};
        ext   = rword;
        case (bus.req_size)
            2'd0: ext = bus.req_unsigned ?
                        {24'd0, sh[7:0]} :
                        {{24{sh[7]}}, sh[7:0]};
            2'd1: ext = bus.req_unsigned ?
                        {16'd0, sh[15:0]} :
                        {{16{sh[15]}}, sh[15:0]};
            default: ext = rword;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rdata_q <= rdata_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rdata_n = rdata_q;
        err_n   = err_q;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    err_n   = err_now;
                    rdata_n = (err_now || bus.req_write) ?
                              32'd0 : ext;
                    if (LATENCY > 1) begin
                        state_n = WAIT;
                        cnt_n   = CNT_INIT;
                    end else begin
                        state_n = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_n = RESP;
                else             cnt_n   = cnt - 4'd1;
            end
            RESP: begin
                if (bus.resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: a LATENCY=3 instance
// for the main scenarios and a LATENCY=1 one for streaming.
module tb_data_mem_port;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    data_mem_port_if m3();
    data_mem_port_if m1();

    data_mem_port #(.WORDS_LOG2(10), .LATENCY(3), .INIT_FILE(""))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(m3));
    data_mem_port #(.WORDS_LOG2(10), .LATENCY(1), .INIT_FILE(""))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(m1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic req3(
        input  logic        w,
        input  logic [1:0]  sz,
        input  logic        u,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        output logic [31:0] rd,
        output logic        er,
        output int          lat
    );
        m3.req_valid    = 1'b1;
        m3.req_write    = w;
        m3.req_size     = sz;
        m3.req_unsigned = u;
        m3.req_addr     = a;
        m3.req_wdata    = wd;
        @(posedge clk); #1;
        m3.req_valid = 1'b0;
        m3.req_write = 1'b0;
        lat = 1;
        while (!m3.resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (m3.resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL resp_timeout addr=%h got=%b want=1",
                     a, m3.resp_valid);
        end
        rd = m3.resp_rdata;
        er = m3.resp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        checks++;
        if (m3.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_ready got=%b want=1", m3.req_ready);
        end
        checks++;
        if (m3.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid got=%b want=0", m3.resp_valid);
        end
        checks++;
        if (m3.resp_rdata !== 32'd0 || m3.resp_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_data got=%h/%b want=0/0",
                     m3.resp_rdata, m3.resp_err);
        end
        checks++;
        if (m1.req_ready !== 1'b1 || m1.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_l1 got=%b/%b want=1/0",
                     m1.req_ready, m1.resp_valid);
        end
    endtask

    task automatic test_word;
        logic [31:0] rd;
        logic        er;
        int          lat;
        req3(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
        checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'd0) begin
            failures++;
            $display("FAIL st_word got=%0d/%b/%h want=3/0/0",
                     lat, er, rd);
        end
        req3(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er, lat);
        checks++;
        if (lat !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL ld_word got=%0d/%b/%h want=3/0/deadbeef",
                     lat, er, rd);
        end
    endtask

    task automatic test_subword;
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] exp_v [6];
        logic [1:0]  szs   [6];
        logic        uns   [6];
        logic [31:0] adrs  [6];
        req3(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF7F, rd, er, lat);
        exp_v = '{32'h0000007F, 32'hDEAD7FEF, 32'hFFFFDEAD,
                  32'h0000DEAD, 32'hFFFFFFDE, 32'h000000EF};
        szs   = '{2'd0, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};
        uns   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        adrs  = '{32'h11, 32'h10, 32'h12, 32'h12, 32'h13, 32'h10};
        for (int i = 0; i < 6; i++) begin
            req3(1'b0, szs[i], uns[i], adrs[i], 32'd0, rd, er, lat);
            checks++;
            if (rd !== exp_v[i] || er !== 1'b0) begin
                failures++;
                $display("FAIL subword%0d got=%h/%b want=%h/0",
                         i, rd, er, exp_v[i]);
            end
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        wr   [6];
        logic [1:0]  szs  [6];
        logic [31:0] adrs [6];
        req3(1'b1, 2'd2, 1'b0, 32'h0, 32'h0, rd, er, lat);
        wr   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        szs  = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2, 2'd1};
        adrs = '{32'h13, 32'h11, 32'h10, 32'h1000,
                 32'h1000, 32'h13};
        for (int i = 0; i < 6; i++) begin
            req3(wr[i], szs[i], 1'b0, adrs[i], 32'hFFFFFFFF,
                 rd, er, lat);
            checks++;
            if (er !== 1'b1 || rd !== 32'd0) begin
                failures++;
                $display("FAIL err%0d got=%b/%h want=1/0", i, er, rd);
            end
        end
        req3(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD7FEF || er !== 1'b0) begin
            failures++;
            $display("FAIL err_keep10 got=%h want=dead7fef", rd);
        end
        req3(1'b0, 2'd2, 1'b0, 32'h0, 32'd0, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            failures++;
            $display("FAIL err_keep00 got=%h want=0", rd);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        m3.resp_ready   = 1'b0;
        m3.req_valid    = 1'b1;
        m3.req_write    = 1'b0;
        m3.req_size     = 2'd2;
        m3.req_unsigned = 1'b0;
        m3.req_addr     = 32'h10;
        @(posedge clk); #1;
        m3.req_valid = 1'b0;
        n = 0;
        while (!m3.resp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        // Offer a store during the stall; it must not be taken.
        m3.req_valid = 1'b1;
        m3.req_write = 1'b1;
        m3.req_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (m3.resp_valid !== 1'b1 || m3.req_ready !== 1'b0 ||
                m3.resp_rdata !== 32'hDEAD7FEF) begin
                failures++;
                $display("FAIL hold%0d got=%b/%b/%h want=1/0/dead7fef",
                         i, m3.resp_valid, m3.req_ready, m3.resp_rdata);
            end
            @(posedge clk); #1;
        end
        m3.req_valid  = 1'b0;
        m3.req_write  = 1'b0;
        m3.resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (m3.req_ready !== 1'b1 || m3.resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL release got=%b/%b want=1/0",
                     m3.req_ready, m3.resp_valid);
        end
        req3(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er, lat);
        checks++;
        if (lat !== 3 || rd !== 32'hDEAD7FEF) begin
            failures++;
            $display("FAIL after_hold got=%0d/%h want=3/dead7fef",
                     lat, rd);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic        er;
        int          lat;
        m3.req_valid = 1'b1;
        m3.req_write = 1'b1;
        m3.req_size  = 2'd2;
        m3.req_addr  = 32'h20;
        m3.req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        m3.req_valid = 1'b0;
        m3.req_write = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m3.req_ready !== 1'b1 || m3.resp_valid !== 1'b0 ||
            m3.resp_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_wait_st got=%b/%b/%b want=1/0/0",
                     m3.req_ready, m3.resp_valid, m3.resp_err);
        end
        #2 rst_n = 1'b1;
        m3.req_valid = 1'b1;
        m3.req_addr  = 32'h10;
        @(posedge clk); #1;
        m3.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m3.resp_rdata !== 32'd0 || m3.resp_valid !== 1'b0 ||
            m3.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_wait_ld got=%h/%b/%b want=0/0/1",
                     m3.resp_rdata, m3.resp_valid, m3.req_ready);
        end
        #2 rst_n = 1'b1;
        req3(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, rd, er, lat);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0 || lat !== 3) begin
            failures++;
            $display("FAIL rst_kept got=%h/%b/%0d want=cafef00d/0/3",
                     rd, er, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] want;
        @(negedge clk);
        m1.req_valid    = 1'b1;
        m1.req_write    = 1'b1;
        m1.req_size     = 2'd2;
        m1.req_unsigned = 1'b0;
        m1.req_addr     = 32'h4;
        m1.req_wdata    = 32'h11223344;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (m1.req_ready !== (k % 2 == 0) ||
                m1.resp_valid !== (k % 2 == 1)) begin
                failures++;
                $display("FAIL b2b%0d got=%b/%b want=%b/%b", k,
                         m1.req_ready, m1.resp_valid,
                         (k % 2 == 0), (k % 2 == 1));
            end
            if (k % 2 == 1) begin
                want = (k == 1) ? 32'd0 : 32'h11223344;
                checks++;
                if (m1.resp_rdata !== want || m1.resp_err !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_data%0d got=%h want=%h",
                             k, m1.resp_rdata, want);
                end
            end
            if (k == 1) m1.req_write = 1'b0;
            @(negedge clk);
        end
        m1.req_valid = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        m3.req_valid = 1'b0; m3.req_write = 1'b0;
        m3.req_size = 2'd0; m3.req_unsigned = 1'b0;
        m3.req_addr = 32'd0; m3.req_wdata = 32'd0;
        m3.resp_ready = 1'b1;
        m1.req_valid = 1'b0; m1.req_write = 1'b0;
        m1.req_size = 2'd0; m1.req_unsigned = 1'b0;
        m1.req_addr = 32'd0; m1.req_wdata = 32'd0;
        m1.resp_ready = 1'b1;
        #2;
        test_reset();
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        test_word();
        test_subword();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
